tipi_mailbox: RTL and testbench

Parametrised, clocked successor to the TIPI bus glue. Provides NCH bidirectional byte mailboxes between the TI-99/4A memory bus and the Raspberry Pi, plus a CRU_BITS-wide CRU control register.
- TI bus strobes and the RPi serial link are synchronised into clk.
- TI writes produce per-channel strobes.
- RPi→TI registers load through a framed serial shift port with error checking.
- Sits between the TI edge connector buffers and the RPi GPIO header, beside the DSR ROM.

---
 rtl/tipi_mailbox_pkg.sv | 25 ++
 rtl/tipi_mailbox_if.sv | 33 +++
 rtl/tipi_mailbox_sync_edge.sv | 34 +++
 rtl/tipi_mailbox.sv | 244 ++++++++++++++++++++++++
 tb/tb_tipi_mailbox.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tipi_mailbox_pkg.sv
// tipi_pkg: constants and types shared by the TIPI mailbox files.
//   TIPI_WR_TOP / TIPI_RD_TOP : default channel-0 addresses. Each further
//                               channel sits 4 bytes lower.
//   CRU_PREFIX                : high nibble of every CRU address (0x1n00).
//   CRU_DSR_EN / CRU_RPI_RST  : named CRU control bit positions.
//   ser_state_e               : serial frame port states.
package tipi_pkg;

  localparam logic [15:0] TIPI_WR_TOP = 16'h5FFF;
  localparam logic [15:0] TIPI_RD_TOP = 16'h5FFB;
  localparam logic [3:0]  CRU_PREFIX  = 4'h1;
  localparam int          CRU_DSR_EN  = 0;
  localparam int          CRU_RPI_RST = 1;

  typedef enum logic {
    SER_SHIFT  = 1'b0,
    SER_COMMIT = 1'b1
  } ser_state_e;

  // Address of mailbox channel idx, counting down from top in steps of 4.
  function automatic logic [15:0] chan_addr(input logic [15:0] top, input int idx);
    return top - 16'(4 * idx);
  endfunction

endpackage

// File: rtl/tipi_mailbox_if.sv
// tipi_mailbox_if: TI-99/4A bus and RPi serial link signals.
//   TI side : ti_a[0:15] (bit 0 = MSB), ti_data[0:7], ti_memen/ti_we/ti_cruclk
//             (active low), ti_dbin (active high), ti_dout[0:7] and
//             ti_dbus_oe (active low) back toward the bus transmitter.
//   RPi side: rpi_sclk, rpi_sdata (MSB first), rpi_le (frame commit).
//   master = bus/RPi driver, slave = mailbox.
interface tipi_mailbox_if;

  logic [0:15] ti_a;
  logic [0:7]  ti_data;
  logic        ti_memen;
  logic        ti_we;
  logic        ti_dbin;
  logic        ti_cruclk;
  logic [0:7]  ti_dout;
  logic        ti_dbus_oe;
  logic        rpi_sclk;
  logic        rpi_sdata;
  logic        rpi_le;

  modport master (
    output ti_a, ti_data, ti_memen, ti_we, ti_dbin, ti_cruclk,
    output rpi_sclk, rpi_sdata, rpi_le,
    input  ti_dout, ti_dbus_oe
  );

  modport slave (
    input  ti_a, ti_data, ti_memen, ti_we, ti_dbin, ti_cruclk,
    input  rpi_sclk, rpi_sdata, rpi_le,
    output ti_dout, ti_dbus_oe
  );

endinterface

// File: rtl/tipi_mailbox_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous level, plus a third
// flop used to produce single-cycle rise/fall pulses.
//   clk, rst : clock, async active-high reset (flops reset to RST_VAL)
//   d        : asynchronous input
//   q        : synchronised level
//   rise     : one-cycle pulse when q goes 0->1
//   fall     : one-cycle pulse when q goes 1->0
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {3{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q    = sync_q[1];
  assign rise =  sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/tipi_mailbox.sv
// tipi_mailbox: NCH byte mailboxes in each direction between the TI-99/4A
// memory bus and the Raspberry Pi, plus a CRU_BITS-wide CRU control register.
//   clk, rst   : system clock, async active-high reset
//   bus        : TI bus + RPi serial link (tipi_mailbox_if.slave)
//   cru_base   : CRU base nibble n of 0x1n00
//   td_regs    : TI->RPi registers, channel 0 in the LSBs
//   td_strobe  : one-cycle pulse per completed TI write, per channel
//   cru_state  : CRU bits, bit 0 = DSR enable
//   rpi_reset  : inverse of CRU bit 1
//   frame_err  : sticky serial frame error, cleared by the next good frame
//
// Serial port FSM:
//   state      | meaning
//   SER_SHIFT  | shift bits in on sclk rises; le rise moves to commit
//   SER_COMMIT | check the frame, write rd[channel] or flag error, clear count
module tipi_mailbox
  import tipi_pkg::*;
#(
  parameter int          NCH      = 2,
  parameter int          DW       = 8,
  parameter int          CHW      = 3,
  parameter int          CRU_BITS = 4,
  parameter logic [15:0] WR_TOP   = TIPI_WR_TOP,
  parameter logic [15:0] RD_TOP   = TIPI_RD_TOP
) (
  input  logic                clk,
  input  logic                rst,
  tipi_mailbox_if.slave       bus,
  input  logic [3:0]          cru_base,
  output logic [NCH*DW-1:0]   td_regs,
  output logic [NCH-1:0]      td_strobe,
  output logic [CRU_BITS-1:0] cru_state,
  output logic                rpi_reset,
  output logic                frame_err
);

  localparam int FW = CHW + DW;
  localparam int CW = $clog2(FW + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FW);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

  // ---------------------------------------------------------------- syncs
  logic we_s, we_rise, we_fall;
  logic memen_s, memen_rise, memen_fall;
  logic cruclk_s, cruclk_rise, cruclk_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic le_s, le_rise, le_fall;

  sync_edge #(.RST_VAL(1'b1)) u_sync_we (
    .clk(clk), .rst(rst), .d(bus.ti_we),
    .q(we_s), .rise(we_rise), .fall(we_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_sync_memen (
    .clk(clk), .rst(rst), .d(bus.ti_memen),
    .q(memen_s), .rise(memen_rise), .fall(memen_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_sync_cruclk (
    .clk(clk), .rst(rst), .d(bus.ti_cruclk),
    .q(cruclk_s), .rise(cruclk_rise), .fall(cruclk_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(bus.rpi_sclk),
    .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_sync_le (
    .clk(clk), .rst(rst), .d(bus.rpi_le),
    .q(le_s), .rise(le_rise), .fall(le_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{we_fall, memen_rise, memen_fall, cruclk_s, cruclk_rise,
                         sclk_s, sclk_fall, le_s, le_fall};

  // ---------------------------------------------------------------- state
  logic [DW-1:0]       td_q [NCH];
  logic [DW-1:0]       td_d [NCH];
  logic [DW-1:0]       rd_q [NCH];
  logic [DW-1:0]       rd_d [NCH];
  logic [NCH-1:0]      pend_q, pend_d;
  logic [NCH-1:0]      strobe_q, strobe_d;
  logic [CRU_BITS-1:0] cru_q, cru_d;
  logic [FW-1:0]       sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ferr_q, ferr_d;
  ser_state_e          state_q, state_d;

  // ---------------------------------------------------------------- decode
  logic           wr_access, rd_access;
  logic [NCH-1:0] wr_hit, rd_hit;

  // Writes use the synchronised strobes; reads stay raw so ti_dout meets
  // the TI bus read timing.
  assign wr_access = ~we_s & ~memen_s & cru_q[CRU_DSR_EN];
  assign rd_access = cru_q[CRU_DSR_EN] & ~bus.ti_memen & bus.ti_dbin;

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_hit[i] = wr_access & (bus.ti_a == chan_addr(WR_TOP, i));
      rd_hit[i] = rd_access & (bus.ti_a == chan_addr(RD_TOP, i));
    end
  end

  // ---------------------------------------------------------------- TI write
  // A channel is pending once it has seen a write cycle; the synced we rise
  // that ends the cycle turns the pending flag into a registered strobe.
  always_comb begin
    td_d     = td_q;
    pend_d   = pend_q;
    strobe_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_hit[i]) td_d[i] = DW'(bus.ti_data);
      if (we_rise) begin
        strobe_d[i] = pend_q[i];
        pend_d[i]   = 1'b0;
      end else if (wr_hit[i]) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- TI read
  // oe depends only on the decode, never on rd contents, so a commit into
  // the register being read can change ti_dout but not ti_dbus_oe.
  logic [7:0] dout_c;
  logic       oe_c;

  always_comb begin
    dout_c = '0;
    oe_c   = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (rd_hit[i]) begin
        dout_c = dout_c | 8'(rd_q[i]);
        oe_c   = 1'b0;
      end
    end
  end

  assign bus.ti_dout    = dout_c;
  assign bus.ti_dbus_oe = oe_c;

  // ---------------------------------------------------------------- CRU
  logic [6:0] cru_idx;

  always_comb begin
    cru_d   = cru_q;
    cru_idx = bus.ti_a[8:14];
    if (cruclk_fall && (bus.ti_a[0:3] == CRU_PREFIX) && (bus.ti_a[4:7] == cru_base)) begin
      for (int j = 0; j < CRU_BITS; j++) begin
        if (cru_idx == 7'(j)) cru_d[j] = bus.ti_a[15];
      end
    end
  end

  // ---------------------------------------------------------------- serial
  logic [CHW-1:0] ser_chan;
  logic [DW-1:0]  ser_data;

  assign ser_chan = sh_q[FW-1:DW];
  assign ser_data = sh_q[DW-1:0];

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    ferr_d  = ferr_q;
    rd_d    = rd_q;
    case (state_q)
      SER_SHIFT: begin
        // A shift in the le-rise cycle lands before the commit looks at it.
        if (sclk_rise) begin
          sh_d = {sh_q[FW-2:0], bus.rpi_sdata};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        end
        if (le_rise) state_d = SER_COMMIT;
      end
      SER_COMMIT: begin
        if ((cnt_q == CNT_FULL) && (int'(ser_chan) < NCH)) begin
          for (int i = 0; i < NCH; i++) begin
            if (int'(ser_chan) == i) rd_d[i] = ser_data;
          end
          ferr_d = 1'b0;
        end else begin
          ferr_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = SER_SHIFT;
        // An sclk rise here already belongs to the next frame.
        if (sclk_rise) begin
          sh_d  = {sh_q[FW-2:0], bus.rpi_sdata};
          cnt_d = CW'(1);
        end
      end
      default: state_d = SER_SHIFT;
    endcase
  end

  // ---------------------------------------------------------------- flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        td_q[i] <= '0;
        rd_q[i] <= '0;
      end
      pend_q   <= '0;
      strobe_q <= '0;
      cru_q    <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      ferr_q   <= 1'b0;
      state_q  <= SER_SHIFT;
    end else begin
      td_q     <= td_d;
      rd_q     <= rd_d;
      pend_q   <= pend_d;
      strobe_q <= strobe_d;
      cru_q    <= cru_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      ferr_q   <= ferr_d;
      state_q  <= state_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    td_regs = '0;
    for (int i = 0; i < NCH; i++) td_regs[i*DW +: DW] = td_q[i];
  end

  assign td_strobe = strobe_q;
  assign cru_state = cru_q;
  assign frame_err = ferr_q;

  generate
    if (CRU_BITS > CRU_RPI_RST) begin : g_rpi_rst
      assign rpi_reset = ~cru_q[CRU_RPI_RST];
    end else begin : g_no_rpi_rst
      assign rpi_reset = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_tipi_mailbox.sv
module tb_tipi_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cru_base;
  logic [15:0] td_regs;
  logic [1:0]  td_strobe;
  logic [3:0]  cru_state;
  logic        rpi_reset;
  logic        frame_err;

  int tests = 0;
  int fails = 0;

  logic [15:0] td_exp_q [$];
  logic [7:0]  rd_exp_q [$];

  tipi_mailbox_if bus ();

  tipi_mailbox #(
    .NCH(2), .DW(8), .CHW(3), .CRU_BITS(4),
    .WR_TOP(16'h5FFF), .RD_TOP(16'h5FFB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .cru_base(cru_base),
    .td_regs(td_regs), .td_strobe(td_strobe), .cru_state(cru_state),
    .rpi_reset(rpi_reset), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cru_write(input logic [15:0] addr);
    bus.ti_a = addr;
    tick(2);
    bus.ti_cruclk = 1'b0;
    tick(4);
    bus.ti_cruclk = 1'b1;
    tick(4);
  endtask

  // Write cycle, then watch both strobes after the raw we rise.
  task automatic ti_write(input logic [15:0] addr, input logic [7:0] data,
                          output int c0, output int c1, output int l0, output int l1);
    c0 = 0; c1 = 0; l0 = 0; l1 = 0;
    bus.ti_a = addr;
    bus.ti_data = data;
    bus.ti_dbin = 1'b0;
    bus.ti_memen = 1'b0;
    bus.ti_we = 1'b0;
    tick(5);
    bus.ti_we = 1'b1;
    bus.ti_memen = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (td_strobe[0]) begin c0++; if (l0 == 0) l0 = k; end
      if (td_strobe[1]) begin c1++; if (l1 == 0) l1 = k; end
    end
  endtask

  task automatic ti_read(input logic [15:0] addr, output logic [7:0] dout, output logic oe);
    bus.ti_a = addr;
    bus.ti_memen = 1'b0;
    bus.ti_dbin = 1'b1;
    #1;
    dout = bus.ti_dout;
    oe = bus.ti_dbus_oe;
    tick(1);
    bus.ti_memen = 1'b1;
    bus.ti_dbin = 1'b0;
  endtask

  task automatic ser_bits(input logic [15:0] val, input int n);
    for (int b = n - 1; b >= 0; b--) begin
      bus.rpi_sdata = val[b];
      tick(2);
      bus.rpi_sclk = 1'b1;
      tick(3);
      bus.rpi_sclk = 1'b0;
      tick(2);
    end
  endtask

  task automatic ser_commit();
    bus.rpi_le = 1'b1;
    tick(3);
    bus.rpi_le = 1'b0;
    tick(4);
  endtask

  initial begin
    int c0, c1, l0, l1, sc;
    logic [7:0]  d;
    logic        oe;
    logic [15:0] exp16;
    logic [7:0]  exp8;

    rst = 1'b1;
    cru_base = 4'h1;
    bus.ti_a = '0; bus.ti_data = '0;
    bus.ti_memen = 1'b1; bus.ti_we = 1'b1; bus.ti_dbin = 1'b0; bus.ti_cruclk = 1'b1;
    bus.rpi_sclk = 1'b0; bus.rpi_sdata = 1'b0; bus.rpi_le = 1'b0;
    tick(3);

    // 1: reset state and CRU writes
    check("rst_cru_state", cru_state, 4'h0);
    check("rst_rpi_reset", rpi_reset, 1'b1);
    check("rst_td_regs", td_regs, 16'h0000);
    check("rst_td_strobe", td_strobe, 2'b00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_oe", bus.ti_dbus_oe, 1'b1);
    rst = 1'b0;
    tick(2);
    check("post_rst_rpi_reset", rpi_reset, 1'b1);
    cru_write(16'h1101);
    check("cru_bit0", cru_state, 4'b0001);
    check("cru_bit0_rpi_reset", rpi_reset, 1'b1);
    cru_write(16'h1103);
    check("cru_bit1", cru_state, 4'b0011);
    check("cru_bit1_rpi_reset", rpi_reset, 1'b0);
    cru_write(16'h1109);
    check("cru_idx_oob", cru_state, 4'b0011);
    cru_write(16'h1200);
    check("cru_wrong_base", cru_state, 4'b0011);

    // 2: TI writes
    td_exp_q.push_back(16'h00A5);
    ti_write(16'h5FFF, 8'hA5, c0, c1, l0, l1);
    check("wr0_strobe0_count", c0, 1);
    check("wr0_strobe0_latency", l0, 3);
    check("wr0_strobe1_count", c1, 0);
    exp16 = td_exp_q.pop_front();
    check("wr0_td_regs", td_regs, exp16);
    td_exp_q.push_back(16'h3CA5);
    ti_write(16'h5FFB, 8'h3C, c0, c1, l0, l1);
    check("wr1_strobe0_count", c0, 0);
    check("wr1_strobe1_count", c1, 1);
    check("wr1_strobe1_latency", l1, 3);
    exp16 = td_exp_q.pop_front();
    check("wr1_td_regs", td_regs, exp16);
    ti_read(16'h5FFB, d, oe);
    check("wr1_rd0_untouched", d, 8'h00);
    ti_write(16'h5FF7, 8'h77, c0, c1, l0, l1);
    check("wr_miss_strobes", c0 + c1, 0);
    check("wr_miss_td_regs", td_regs, 16'h3CA5);

    // 3: valid serial frame to channel 1
    rd_exp_q.push_back(8'h5A);
    ser_bits({5'd0, 3'd1, 8'h5A}, 11);
    ser_commit();
    ti_read(16'h5FF7, d, oe);
    exp8 = rd_exp_q.pop_front();
    check("ser1_dout", d, exp8);
    check("ser1_oe", oe, 1'b0);
    check("ser1_frame_err", frame_err, 1'b0);

    // 4: short frame, then valid frame to channel 0
    ser_bits(16'h00F0, 10);
    ser_commit();
    check("short_frame_err", frame_err, 1'b1);
    ti_read(16'h5FF7, d, oe);
    check("short_rd1_kept", d, 8'h5A);
    ti_read(16'h5FFB, d, oe);
    check("short_rd0_kept", d, 8'h00);
    rd_exp_q.push_back(8'hFF);
    ser_bits({5'd0, 3'd0, 8'hFF}, 11);
    ser_commit();
    check("ser0_frame_err", frame_err, 1'b0);
    ti_read(16'h5FFB, d, oe);
    exp8 = rd_exp_q.pop_front();
    check("ser0_dout", d, exp8);

    // 5: bad channel, DSR disable
    ser_bits({5'd0, 3'd5, 8'h11}, 11);
    ser_commit();
    check("badch_frame_err", frame_err, 1'b1);
    ti_read(16'h5FFB, d, oe);
    check("badch_rd0_kept", d, 8'hFF);
    ti_read(16'h5FF7, d, oe);
    check("badch_rd1_kept", d, 8'h5A);
    cru_write(16'h1100);
    check("dsr_off_cru", cru_state, 4'b0010);
    ti_read(16'h5FFB, d, oe);
    check("dsr_off_oe", oe, 1'b1);
    check("dsr_off_dout", d, 8'h00);
    ti_write(16'h5FFF, 8'h99, c0, c1, l0, l1);
    check("dsr_off_strobes", c0 + c1, 0);
    check("dsr_off_td_regs", td_regs, 16'h3CA5);
    rd_exp_q.push_back(8'h33);
    ser_bits({5'd0, 3'd1, 8'h33}, 11);
    ser_commit();
    check("dsr_off_ser_err", frame_err, 1'b0);
    cru_write(16'h1101);
    ti_read(16'h5FF7, d, oe);
    exp8 = rd_exp_q.pop_front();
    check("dsr_off_ser_dout", d, exp8);

    // 6: reset during a write cycle and during a partial frame
    bus.ti_a = 16'h5FFF;
    bus.ti_data = 8'h5C;
    bus.ti_memen = 1'b0;
    bus.ti_we = 1'b0;
    tick(5);
    sc = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (td_strobe != 2'b00) sc++;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (td_strobe != 2'b00) sc++;
    end
    bus.ti_we = 1'b1;
    bus.ti_memen = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (td_strobe != 2'b00) sc++;
    end
    check("rst_mid_strobes", sc, 0);
    check("rst_mid_td_regs", td_regs, 16'h0000);
    check("rst_mid_cru", cru_state, 4'h0);
    check("rst_mid_rpi_reset", rpi_reset, 1'b1);

    cru_write(16'h1101);
    ser_bits(16'h003F, 6);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    cru_write(16'h1101);
    rd_exp_q.push_back(8'hC3);
    ser_bits({5'd0, 3'd1, 8'hC3}, 11);
    ser_commit();
    check("partial_frame_err", frame_err, 1'b0);
    ti_read(16'h5FF7, d, oe);
    exp8 = rd_exp_q.pop_front();
    check("partial_rd1", d, exp8);
    ti_read(16'h5FFB, d, oe);
    check("partial_rd0_reset", d, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
